// File: rtl/bram_reader_pkg.sv
// Shared types and defaults for the BRAM read client: state encoding and
// the read-credit rule used to keep the output FIFO from overflowing.
package bram_reader_pkg;

    localparam int ADDR_BITS_DEF  = 11;
    localparam int DATA_BITS_DEF  = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A read may issue only if every byte already owed to the FIFO, plus this
    // one, still fits once this cycle's pop has been accounted for.
    function automatic logic credit_ok(input int unsigned occ,
                                       input int unsigned in_flight,
                                       input logic        pop,
                                       input int unsigned depth);
        return (occ + in_flight) < (depth + 32'(pop));
    endfunction

endpackage

// File: rtl/bram_reader_fifo.sv
// Small synchronous FIFO used as the output skid buffer of bram_reader.
module bram_reader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_eff_s, pop_eff_s;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == CW'(0));
    assign count = count_q;
    assign dout  = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; a push on a full FIFO
    // is accepted only when the same cycle frees a slot.
    always_comb begin
        pop_eff_s  = pop && !empty;
        push_eff_s = push && (!full || pop_eff_s);
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (push_eff_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? PW'(0) : wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_eff_s) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? PW'(0) : rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_eff_s, pop_eff_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            rd_ptr_q <= PW'(0);
            wr_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bram_reader.sv
// Walks a contiguous BRAM address range on command and streams the bytes
// out through a small FIFO, absorbing the one-cycle BRAM read latency.
module bram_reader
    import bram_reader_pkg::*;
#(
    parameter int ADDR_BITS  = ADDR_BITS_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   length,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS-1:0] rdaddress,
    output logic                 oen,
    input  logic [DATA_BITS-1:0] bram_data,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS:0]   issue_left_q, issue_left_d;
    logic [ADDR_BITS:0]   xfer_left_q, xfer_left_d;
    logic                 oen_q, oen_d;
    logic [ADDR_BITS-1:0] rdaddr_q, rdaddr_d;
    logic                 push_q, push_d;

    logic                 busy_s, done_s;
    logic                 go_s, pop_s, issue_s;
    logic [ADDR_BITS-1:0] cur_addr_s;
    logic [ADDR_BITS:0]   cur_left_s;
    logic [FCW-1:0]       fifo_count_s;
    logic                 fifo_full_s, fifo_empty_s;

    assign busy      = busy_s;
    assign done      = done_s;
    assign oen       = oen_q;
    assign rdaddress = rdaddr_q;
    assign out_valid = !fifo_empty_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (length == {(ADDR_BITS+1){1'b0}}) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_left_q == {(ADDR_BITS+1){1'b0}}) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pop_s && (xfer_left_q == (ADDR_BITS+1)'(1))) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        case (state_q)
            ST_RUN, ST_DRAIN: begin busy_s = 1'b1; done_s = 1'b0; end
            ST_DONE:          begin busy_s = 1'b0; done_s = 1'b1; end
            default:          begin busy_s = 1'b0; done_s = 1'b0; end
        endcase
    end

    // Address walk, read credit and byte accounting. The first read issues in
    // the same cycle start is sampled, straight from base_addr/length.
    always_comb begin
        go_s       = (state_q == ST_IDLE) && start;
        pop_s      = !fifo_empty_s && out_ready;
        cur_addr_s = go_s ? base_addr : addr_q;
        cur_left_s = go_s ? length : issue_left_q;
        issue_s    = (go_s || (state_q == ST_RUN))
                     && (cur_left_s != {(ADDR_BITS+1){1'b0}})
                     && credit_ok(32'(fifo_count_s), 32'(oen_q) + 32'(push_q),
                                  pop_s, FIFO_DEPTH)
                     && (!fifo_full_s || pop_s);

        push_d = oen_q;
        if (issue_s) begin
            oen_d        = 1'b1;
            rdaddr_d     = cur_addr_s;
            addr_d       = cur_addr_s + ADDR_BITS'(1);
            issue_left_d = cur_left_s - (ADDR_BITS+1)'(1);
        end else if (go_s) begin
            oen_d        = 1'b0;
            rdaddr_d     = rdaddr_q;
            addr_d       = base_addr;
            issue_left_d = length;
        end else begin
            oen_d        = 1'b0;
            rdaddr_d     = rdaddr_q;
            addr_d       = addr_q;
            issue_left_d = issue_left_q;
        end

        if (go_s) begin
            xfer_left_d = length;
        end else if (pop_s) begin
            xfer_left_d = xfer_left_q - (ADDR_BITS+1)'(1);
        end else begin
            xfer_left_d = xfer_left_q;
        end
    end

    // Datapath registers; push_q marks the cycle bram_data is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= {ADDR_BITS{1'b0}};
            issue_left_q <= {(ADDR_BITS+1){1'b0}};
            xfer_left_q  <= {(ADDR_BITS+1){1'b0}};
            oen_q        <= 1'b0;
            rdaddr_q     <= {ADDR_BITS{1'b0}};
            push_q       <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            xfer_left_q  <= xfer_left_d;
            oen_q        <= oen_d;
            rdaddr_q     <= rdaddr_d;
            push_q       <= push_d;
        end
    end

    bram_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .din   (bram_data),
        .pop   (pop_s),
        .dout  (out_data),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

endmodule

// File: tb/tb_bram_reader.sv
// Randomized bench for bram_reader against a behavioural BRAM and a simple
// address/byte model (mem[a] = a[7:0] ^ 8'hA5, addresses wrap mod 2048).
module tb_bram_reader;

    localparam int AB = 11;
    localparam int DB = 8;
    localparam int FD = 4;
    localparam int MEMSZ = 2048;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AB-1:0] base_addr = '0;
    logic [AB:0]   length = '0;
    logic          busy, done, oen, out_valid;
    logic [AB-1:0] rdaddress;
    logic [DB-1:0] bram_data = '0;
    logic [DB-1:0] out_data;
    logic          out_ready = 1'b1;

    logic [7:0] mem [MEMSZ];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int ready_pct = 100;

    logic [7:0] got_q [$];
    int         addr_q [$];
    int issued, popped, first_valid_cyc, first_xfer_cyc, last_xfer_cyc;
    int done_cyc, done_cnt;
    logic prev_stall;
    logic [7:0] prev_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (oen) bram_data <= mem[rdaddress];

    bram_reader #(.ADDR_BITS(AB), .DATA_BITS(DB), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .rdaddress(rdaddress), .oen(oen),
        .bram_data(bram_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int a);
        int w;
        w = a % MEMSZ;
        return 8'(w) ^ 8'hA5;
    endfunction

    task automatic clear_mon();
        got_q.delete();
        addr_q.delete();
        issued = 0; popped = 0; done_cnt = 0;
        first_valid_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
    endtask

    // Stream/port monitor, sampled on the falling edge.
    initial begin
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", 32'(out_data), 32'(prev_data));
                end
                if (oen) begin
                    addr_q.push_back(int'(rdaddress));
                    issued++;
                    check("credit", 32'((issued - popped) <= FD), 32'd1);
                end
                if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (out_valid && out_ready) begin
                    got_q.push_back(out_data);
                    popped++;
                    if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                    last_xfer_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("busy_at_done", 32'(busy), 32'd0);
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    // Random backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1 out_ready = ($urandom_range(99) < ready_pct);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic run_cmd(input int base, input int len, input int pct,
                           input bit repulse, input string tag);
        int c0;
        int budget;
        ready_pct = pct;
        clear_mon();
        @(posedge clk);
        #2;
        base_addr = AB'(base);
        length    = (AB+1)'(len);
        start     = 1'b1;
        @(posedge clk);
        #2;
        c0 = cyc;
        start = 1'b0;
        if (repulse) begin
            repeat (3) @(posedge clk);
            #2;
            base_addr = AB'(base + 100);
            length    = (AB+1)'(7);
            start     = 1'b1;
            @(posedge clk);
            #2;
            start = 1'b0;
        end
        budget = 20 * len + 50;
        for (int k = 0; k < budget && done_cnt == 0; k++) @(posedge clk);
        if (done_cnt == 0) check({tag, " timeout"}, 32'd0, 32'd1);
        repeat (12) @(posedge clk);
        check({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, " n_bytes"}, 32'(got_q.size()), 32'(len));
        check({tag, " n_reads"}, 32'(issued), 32'(len));
        for (int i = 0; i < len && i < got_q.size(); i++)
            check($sformatf("%s byte%0d", tag, i), 32'(got_q[i]), 32'(exp_byte(base + i)));
        for (int i = 0; i < len && i < addr_q.size(); i++)
            check($sformatf("%s addr%0d", tag, i), 32'(addr_q[i]), 32'((base + i) % MEMSZ));
        if (len == 0) begin
            check({tag, " no_valid"}, 32'(first_valid_cyc), 32'hFFFF_FFFF);
            check({tag, " done_lat"}, 32'(done_cyc), 32'(c0));
        end else begin
            check({tag, " first_valid"}, 32'(first_valid_cyc), 32'(c0 + 2));
            check({tag, " done_after_last"}, 32'(done_cyc), 32'(last_xfer_cyc + 1));
            if (pct >= 100)
                check({tag, " one_per_clk"}, 32'(last_xfer_cyc - first_xfer_cyc), 32'(len - 1));
        end
    endtask

    initial begin
        for (int i = 0; i < MEMSZ; i++) mem[i] = 8'(i) ^ 8'hA5;
        clear_mon();
        repeat (3) @(posedge clk);
        #2;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst oen", 32'(oen), 32'd0);
        check("rst rdaddress", 32'(rdaddress), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        rst = 1'b0;

        run_cmd(32'h010, 4, 100, 1'b0, "basic");
        run_cmd(32'h7FE, 4, 100, 1'b0, "wrap");
        run_cmd(32'h123, 16, 30, 1'b0, "stall30");
        run_cmd(32'h055, 0, 100, 1'b0, "len0");
        run_cmd(32'h200, 12, 60, 1'b1, "repulse");
        for (int t = 0; t < 6; t++)
            run_cmd(int'($urandom_range(MEMSZ - 1)), int'($urandom_range(40, 1)),
                    int'($urandom_range(100, 20)), 1'b0, $sformatf("rand%0d", t));
        run_cmd(int'($urandom_range(MEMSZ - 1)), MEMSZ, 100, 1'b0, "fullmem");

        // Reset in the middle of a long command.
        ready_pct = 100;
        clear_mon();
        @(posedge clk);
        #2;
        base_addr = AB'(32'h100);
        length    = (AB+1)'(32);
        start     = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst oen", 32'(oen), 32'd0);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst out_data", 32'(out_data), 32'd0);
        check("midrst rdaddress", 32'(rdaddress), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        check("midrst no_done", 32'(done_cnt), 32'd0);
        run_cmd(32'h000, 2, 100, 1'b0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
